// File: rtl/bram_frame_streamer.sv
// Streams one frame of pixels out of a synchronous-read BRAM into a ready/valid sink.
// Reads are throttled so the 2-entry output FIFO can never overflow.
module bram_frame_streamer #(
  parameter int n      = 13,
  parameter int w      = 16,
  parameter int PIXELS = 6144
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         start,
  output logic [n-1:0] addr,
  output logic         read_write,
  input  logic [w-1:0] bram_data,
  output logic [w-1:0] pix_data,
  output logic         pix_valid,
  input  logic         pix_ready,
  output logic         pix_last,
  output logic         busy,
  output logic         done
);
  localparam logic [n-1:0] LAST_ADDR = n'(PIXELS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t       state_reg, state_next;
  logic [n-1:0] addr_reg, addr_next;
  logic         done_reg, done_next;
  logic         inflight_reg, inflight_last_reg;
  logic [w-1:0] fifo_data_reg [2];
  logic         fifo_last_reg [2];
  logic         wr_ptr_reg, rd_ptr_reg;
  logic [1:0]   count_reg;

  logic         pop, push, issue;
  logic [2:0]   occupancy;

  assign pix_valid = (count_reg != 2'd0);
  assign pop       = pix_valid & pix_ready;
  assign push      = inflight_reg;
  // Words already owned by the FIFO after this edge, counting the read still in flight.
  assign occupancy = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    done_next  = 1'b0;
    issue      = 1'b0;
    case (state_reg)
      IDLE: begin
        addr_next = '0;
        if (start) state_next = FETCH;
      end
      FETCH: begin
        if (occupancy < 3'd2) begin
          issue = 1'b1;
          if (addr_reg == LAST_ADDR) state_next = DRAIN;
          else                       addr_next  = addr_reg + 1'b1;
        end
      end
      DRAIN: begin
        if ((pop && pix_last) || (count_reg == 2'd0 && !inflight_reg)) begin
          state_next = IDLE;
          addr_next  = '0;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_reg         <= IDLE;
      addr_reg          <= '0;
      done_reg          <= 1'b0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      wr_ptr_reg        <= 1'b0;
      rd_ptr_reg        <= 1'b0;
      count_reg         <= 2'd0;
    end else begin
      state_reg         <= state_next;
      addr_reg          <= addr_next;
      done_reg          <= done_next;
      inflight_reg      <= issue;
      inflight_last_reg <= issue && (addr_reg == LAST_ADDR);
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      always_ff @(posedge clk) begin
        if (clear) begin
          fifo_data_reg[gi] <= '0;
          fifo_last_reg[gi] <= 1'b0;
        end else if (push && wr_ptr_reg == 1'(gi)) begin
          fifo_data_reg[gi] <= bram_data;
          fifo_last_reg[gi] <= inflight_last_reg;
        end
      end
    end
  endgenerate

  assign pix_data   = pix_valid ? fifo_data_reg[rd_ptr_reg] : '0;
  assign pix_last   = pix_valid & fifo_last_reg[rd_ptr_reg];
  assign addr       = addr_reg;
  assign busy       = (state_reg != IDLE);
  assign done       = done_reg;
  assign read_write = 1'b0;
endmodule

// File: tb/tb_bram_frame_streamer.sv
// Bench for bram_frame_streamer: full-size frame streamer plus a 4-pixel instance,
// each fed by a BRAM model holding mem[i] = i.
module tb_bram_frame_streamer;
  localparam int N   = 13;
  localparam int W   = 16;
  localparam int PIX = 6144;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         clear, start, pix_ready;
  logic [N-1:0] addr;
  logic         read_write;
  logic [W-1:0] bram_data, pix_data;
  logic         pix_valid, pix_last, busy, done;

  bram_frame_streamer #(.n(N), .w(W), .PIXELS(PIX)) u_dut (
    .clk(clk), .clear(clear), .start(start), .addr(addr), .read_write(read_write),
    .bram_data(bram_data), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_last(pix_last), .busy(busy), .done(done)
  );

  always @(posedge clk) bram_data <= W'(addr);

  logic         clear4, start4, ready4;
  logic [1:0]   addr4;
  logic         rw4;
  logic [W-1:0] bram4, data4;
  logic         valid4, last4, busy4, done4;

  bram_frame_streamer #(.n(2), .w(W), .PIXELS(4)) u_dut4 (
    .clk(clk), .clear(clear4), .start(start4), .addr(addr4), .read_write(rw4),
    .bram_data(bram4), .pix_data(data4), .pix_valid(valid4),
    .pix_ready(ready4), .pix_last(last4), .busy(busy4), .done(done4)
  );

  always @(posedge clk) bram4 <= W'(addr4);

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: transfers must be 0..PIX-1 in order, last on the final one,
  // done exactly one cycle after it, stalled outputs frozen, at most 2 words owed.
  int       exp_idx = 0;
  int       frames_done = 0;
  bit       stall_prev = 0;
  bit       done_due = 0;
  logic [W-1:0] prev_data;
  logic     prev_last;

  always @(negedge clk) begin
    if (clear) begin
      exp_idx    = 0;
      stall_prev = 0;
      done_due   = 0;
    end else begin
      check("done_pulse", done, done_due);
      done_due = 0;
      if (busy) check("fifo_room", (int'(addr) - exp_idx) <= 2, 1);
      if (stall_prev) begin
        check("hold_valid", pix_valid, 1);
        check("hold_data", pix_data, prev_data);
        check("hold_last", pix_last, prev_last);
      end
      if (pix_valid && pix_ready) begin
        check("pix_data", pix_data, exp_idx);
        check("pix_last", pix_last, exp_idx == PIX - 1);
        if (exp_idx == PIX - 1) begin
          exp_idx = 0;
          frames_done++;
          done_due = 1;
        end else begin
          exp_idx++;
        end
      end
      stall_prev = pix_valid && !pix_ready;
      prev_data  = pix_data;
      prev_last  = pix_last;
    end
  end

  int       n4 = 0;
  int       dones4 = 0;
  logic [W-1:0] seq4 [8];
  logic     lastseq4 [8];

  always @(negedge clk) begin
    if (!clear4) begin
      if (done4) dones4++;
      if (valid4 && ready4 && n4 < 8) begin
        seq4[n4]     = data4;
        lastseq4[n4] = last4;
        n4++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int c;
    c = 0;
    while (frames_done < target && c < budget) begin
      tick();
      c++;
    end
    check(name, frames_done, target);
  endtask

  task automatic wait_idx(input int target, input int budget, input string name);
    int c;
    c = 0;
    while (exp_idx != target && c < budget) begin
      tick();
      c++;
    end
    check(name, exp_idx, target);
  endtask

  initial begin
    int cyc;
    int f0;
    clear = 1'b1; start = 1'b0; pix_ready = 1'b1;
    clear4 = 1'b1; start4 = 1'b0; ready4 = 1'b1;
    repeat (3) tick();
    clear = 1'b0; clear4 = 1'b0;

    @(negedge clk);
    check("rst_addr", addr, 0);
    check("rst_valid", pix_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", pix_data, 0);
    check("rst_rw", read_write, 0);
    tick();

    // Full frame, ready held high: latency, throughput, single done.
    pulse_start();
    @(negedge clk);
    check("t1_busy", busy, 1);
    check("t1_addr0", addr, 0);
    check("t1_valid_c0", pix_valid, 0);
    @(negedge clk);
    check("t1_valid_c1", pix_valid, 0);
    check("t1_addr1", addr, 1);
    @(negedge clk);
    check("t1_valid_c2", pix_valid, 1);
    check("t1_first", pix_data, 0);
    cyc = 0;
    while (!done && cyc < 10000) begin
      @(negedge clk);
      cyc++;
    end
    check("t1_cycles_to_done", cyc, PIX);
    check("t1_addr_idle", addr, 0);
    tick();
    check("t1_frames", frames_done, 1);

    // Ready toggling every cycle.
    f0 = frames_done;
    cyc = 0;
    pulse_start();
    while (frames_done < f0 + 1 && cyc < 20000) begin
      pix_ready = ~pix_ready;
      tick();
      cyc++;
    end
    pix_ready = 1'b1;
    check("t2_frames", frames_done, f0 + 1);

    // Ready low for 20 cycles after start: two words buffered, fetch stalls.
    f0 = frames_done;
    pix_ready = 1'b0;
    pulse_start();
    repeat (20) tick();
    check("t3_addr", addr, 2);
    check("t3_valid", pix_valid, 1);
    check("t3_data", pix_data, 0);
    check("t3_busy", busy, 1);
    pix_ready = 1'b1;
    wait_frames(f0 + 1, 10000, "t3_frames");

    // Clear at transfer 100.
    pulse_start();
    wait_idx(100, 500, "t4_reach100");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t4_addr", addr, 0);
    check("t4_data", pix_data, 0);
    check("t4_valid", pix_valid, 0);
    check("t4_last", pix_last, 0);
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    check("t4_rw", read_write, 0);
    tick();
    check("t4_discard", pix_valid, 0);
    f0 = frames_done;
    pulse_start();
    wait_frames(f0 + 1, 10000, "t4_frames");

    // Start during FETCH is ignored.
    f0 = frames_done;
    pulse_start();
    wait_idx(50, 500, "t5_reach50");
    pulse_start();
    wait_frames(f0 + 1, 10000, "t5_frames");
    repeat (20) tick();
    check("t5_idle", busy, 0);
    check("t5_single", frames_done, f0 + 1);

    // PIXELS=4, start held high: back-to-back frames.
    start4 = 1'b1;
    cyc = 0;
    while (n4 < 8 && cyc < 200) begin
      tick();
      cyc++;
    end
    repeat (2) tick();
    start4 = 1'b0;
    check("t6_count", n4, 8);
    for (int i = 0; i < 8; i++) begin
      check("t6_data", seq4[i], i % 4);
      check("t6_last", lastseq4[i], (i % 4) == 3);
    end
    check("t6_dones", dones4, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bram_frame_streamer.md
BRAM_FRAME_STREAMER -- requirements
Module: bram_frame_streamer

Interface
REQ-001 Parameter n, 13, BRAM address width.
REQ-002 Parameter w, 16, pixel word width (RGB565).
REQ-003 Parameter PIXELS, 6144, pixels per frame (96x64 OLED); SHALL satisfy 2 <= PIXELS <= 2**n.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-005 clear  input  1  synchronous active-high reset.
REQ-006 start  input  1  frame request, sampled only in IDLE.
REQ-007 addr  output  n  registered read address to the BRAM.
REQ-008 read_write  output  1  BRAM write enable; SHALL be constant 0.
REQ-009 bram_data  input  w  BRAM read data, valid one clock after addr is sampled.
REQ-010 pix_data  output  w  pixel to the downstream display driver.
REQ-011 pix_valid  output  1  pix_data holds a valid pixel.
REQ-012 pix_ready  input  1  downstream accepts the pixel.
REQ-013 pix_last  output  1  high with the pixel from address PIXELS-1.
REQ-014 busy  output  1  high in FETCH and DRAIN.
REQ-015 done  output  1  single-cycle pulse when the frame ends.

Function
REQ-016 The FSM SHALL have three states: IDLE, FETCH and DRAIN.
REQ-017 IDLE->FETCH SHALL occur on start=1; addr SHALL be 0 in the cycle after that edge.
REQ-018 In FETCH, a read is issued in each cycle where a fetch is permitted; addr SHALL advance by 1 at the edge following each issued read.
REQ-019 Fetch permitted SHALL mean (fifo_count + inflight - pop) < 2, where pop = pix_valid & pix_ready.
REQ-020 inflight SHALL be 1 in the cycle after an issued read, and 0 otherwise.
REQ-021 bram_data SHALL be written into a 2-entry output FIFO at the edge after the read was issued.
REQ-022 pix_data, pix_valid and pix_last SHALL present the FIFO head.
REQ-023 A transfer SHALL occur only when pix_valid and pix_ready are both 1.
REQ-024 While pix_valid=1 and pix_ready=0, pix_data and pix_last SHALL hold stable.
REQ-025 The FIFO SHALL never overflow or drop a word, whatever pix_ready does.
REQ-026 With pix_ready held at 1, throughput SHALL be one pixel per clock after the first.
REQ-027 First pix_valid SHALL be 1 in the cycle after the second rising edge following the edge that sampled start.
REQ-028 After issuing address PIXELS-1, FETCH->DRAIN; addr SHALL hold PIXELS-1 and no further reads SHALL be issued.
REQ-029 DRAIN->IDLE SHALL occur at the edge where the pix_last word transfers, or immediately once the FIFO is empty and inflight=0.
REQ-030 done SHALL be 1 for exactly the cycle after that edge; addr SHALL return to 0 in IDLE.
REQ-031 start while busy=1 SHALL be ignored; start held high through done SHALL begin a new frame in the cycle done is high.
REQ-032 Exactly PIXELS transfers SHALL occur per frame, in ascending address order, with pix_last set only on the final transfer.

Reset
REQ-033 clear=1 SHALL take priority over all other inputs at any time, including mid-frame.
REQ-034 On clear, the FSM SHALL go to IDLE, the FIFO SHALL flush, and inflight SHALL clear.
REQ-035 After clear, the following outputs SHALL all be 0: addr, pix_data, pix_valid, pix_last, busy, done, read_write.
REQ-036 A BRAM word returning in the cycle after clear SHALL be discarded.

Verification
REQ-037 BRAM model with mem[i]=i, pix_ready=1, start pulse -> 6144 transfers with data 0..6143 on consecutive cycles, pix_last only on 6143, one done pulse.
REQ-038 pix_ready toggled 1-0 each cycle -> data sequence unchanged, data stable while stalled, read issue rate never exceeds FIFO room.
REQ-039 pix_ready=0 for 20 cycles right after start -> exactly 2 words buffered, addr stops at 2, no loss after release.
REQ-040 clear asserted at transfer 100 -> next cycle all outputs 0; new start -> frame restarts from address 0.
REQ-041 start pulsed during FETCH at pixel 50 -> ignored, single frame, count 6144.
REQ-042 PIXELS=4, start held high -> back-to-back frames 0,1,2,3,0,1,2,3, one done pulse per frame.
